// File: rtl/reg_resp_checker.sv
// Response checker for a register DUT: delays the stimulus by LATENCY cycles, compares it with
// the DUT output, keeps saturating pass/error counts and latches the first mismatch.
module reg_resp_checker #(
  parameter int DWIDTH      = 32,
  parameter int LATENCY     = 1,
  parameter int CNT_W       = 16,
  parameter int STOP_ON_ERR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [DWIDTH-1:0] stim_in,
  input  logic [DWIDTH-1:0] dut_out,
  output logic              busy,
  output logic [CNT_W-1:0]  pass_cnt,
  output logic [CNT_W-1:0]  err_cnt,
  output logic              err_flag,
  output logic              halted,
  output logic [DWIDTH-1:0] first_exp,
  output logic [DWIDTH-1:0] first_got
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    CHECK = 2'd2,
    HALT  = 2'd3
  } state_t;

  // FILL lasts until the first valid entry reaches the last stage (one cycle minimum when LATENCY=1)
  localparam int              FILL_LAST_I = (LATENCY > 1) ? LATENCY - 2 : 0;
  localparam logic [3:0]      FILL_LAST   = 4'(FILL_LAST_I);
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t              state;
  state_t              state_nxt;
  logic [3:0]          fill_cnt;
  logic [3:0]          fill_cnt_nxt;
  logic [DWIDTH-1:0]   pipe_data [LATENCY];
  logic [LATENCY-1:0]  pipe_vld;
  logic                cmp;
  logic                mism;

  // Compare strobe: the valid pipe alone decides whether the last stage holds a live entry
  always_comb begin
    cmp  = pipe_vld[LATENCY-1] && ((state == FILL) || (state == CHECK));
    mism = 1'b0;
    if (cmp) begin
      mism = (pipe_data[LATENCY-1] != dut_out);
    end else begin
      mism = 1'b0;
    end
  end

  // Next-state logic; a halting mismatch outranks en dropping in the same cycle
  always_comb begin
    state_nxt    = state;
    fill_cnt_nxt = fill_cnt;
    case (state)
      IDLE: begin
        if (en) begin
          state_nxt    = FILL;
          fill_cnt_nxt = 4'd0;
        end else begin
          state_nxt = IDLE;
        end
      end
      FILL: begin
        if (mism && (STOP_ON_ERR != 0)) begin
          state_nxt = HALT;
        end else if (!en) begin
          state_nxt = IDLE;
        end else if (fill_cnt == FILL_LAST) begin
          state_nxt = CHECK;
        end else begin
          fill_cnt_nxt = fill_cnt + 4'd1;
        end
      end
      CHECK: begin
        if (mism && (STOP_ON_ERR != 0)) begin
          state_nxt = HALT;
        end else if (!en) begin
          state_nxt = IDLE;
        end else begin
          state_nxt = CHECK;
        end
      end
      HALT: begin
        state_nxt = HALT;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State, delay line, statistics and first-mismatch capture
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      fill_cnt  <= 4'd0;
      pipe_vld  <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        pipe_data[i] <= '0;
      end
      busy      <= 1'b0;
      halted    <= 1'b0;
      pass_cnt  <= '0;
      err_cnt   <= '0;
      err_flag  <= 1'b0;
      first_exp <= '0;
      first_got <= '0;
    end else begin
      state    <= state_nxt;
      fill_cnt <= fill_cnt_nxt;
      busy     <= (state_nxt == FILL) || (state_nxt == CHECK);
      halted   <= (state_nxt == HALT);

      // Leaving FILL/CHECK for IDLE drops every in-flight entry
      if ((state_nxt == IDLE) && (state != IDLE)) begin
        pipe_vld <= '0;
        for (int i = 0; i < LATENCY; i++) begin
          pipe_data[i] <= '0;
        end
      end else begin
        pipe_vld[0]  <= en;
        pipe_data[0] <= stim_in;
        for (int i = 1; i < LATENCY; i++) begin
          pipe_vld[i]  <= pipe_vld[i-1];
          pipe_data[i] <= pipe_data[i-1];
        end
      end

      if (mism) begin
        if (err_cnt != CNT_MAX) begin
          err_cnt <= err_cnt + CNT_ONE;
        end else begin
          err_cnt <= err_cnt;
        end
        if (!err_flag) begin
          err_flag  <= 1'b1;
          first_exp <= pipe_data[LATENCY-1];
          first_got <= dut_out;
        end else begin
          err_flag  <= err_flag;
        end
      end else if (cmp) begin
        if (pass_cnt != CNT_MAX) begin
          pass_cnt <= pass_cnt + CNT_ONE;
        end else begin
          pass_cnt <= pass_cnt;
        end
      end else begin
        pass_cnt <= pass_cnt;
      end
    end
  end

endmodule

// File: tb/tb_reg_resp_checker.sv
// Scoreboard bench: four checker configurations share one randomized stimulus stream; a
// reference model predicts every output after each edge and a monitor compares them.
module tb_reg_resp_checker;

  typedef struct packed {
    logic        busy;
    logic        halted;
    logic        err_flag;
    logic [15:0] pass;
    logic [15:0] err;
    logic [31:0] fexp;
    logic [31:0] fgot;
  } snap_t;
  typedef snap_t [3:0] snap4_t;

  localparam int LAT [4] = '{1, 3, 1, 2};
  localparam int CW  [4] = '{16, 16, 16, 4};
  localparam int SOE [4] = '{0, 0, 1, 0};

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [31:0] stim;
  logic [31:0] dout    [4];
  logic        busy_o  [4];
  logic        halt_o  [4];
  logic        flag_o  [4];
  logic [15:0] pass_o  [4];
  logic [15:0] err_o   [4];
  logic [31:0] fexp_o  [4];
  logic [31:0] fgot_o  [4];
  logic [3:0]  pass3;
  logic [3:0]  err3;

  int     n_checks = 0;
  int     n_fail   = 0;
  bit     done     = 1'b0;
  snap4_t exp_q [$];

  // reference model state
  snap_t       m [4];
  int          run = 0;
  int          k   = 0;
  logic [31:0] hist  [16];
  logic [31:0] fhist [16];

  always #5 clk = ~clk;

  assign pass_o[3] = {12'd0, pass3};
  assign err_o[3]  = {12'd0, err3};

  reg_resp_checker #(.DWIDTH(32), .LATENCY(1), .CNT_W(16), .STOP_ON_ERR(0)) u0 (
    .clk(clk), .rst(rst), .en(en), .stim_in(stim), .dut_out(dout[0]), .busy(busy_o[0]),
    .pass_cnt(pass_o[0]), .err_cnt(err_o[0]), .err_flag(flag_o[0]), .halted(halt_o[0]),
    .first_exp(fexp_o[0]), .first_got(fgot_o[0]));
  reg_resp_checker #(.DWIDTH(32), .LATENCY(3), .CNT_W(16), .STOP_ON_ERR(0)) u1 (
    .clk(clk), .rst(rst), .en(en), .stim_in(stim), .dut_out(dout[1]), .busy(busy_o[1]),
    .pass_cnt(pass_o[1]), .err_cnt(err_o[1]), .err_flag(flag_o[1]), .halted(halt_o[1]),
    .first_exp(fexp_o[1]), .first_got(fgot_o[1]));
  reg_resp_checker #(.DWIDTH(32), .LATENCY(1), .CNT_W(16), .STOP_ON_ERR(1)) u2 (
    .clk(clk), .rst(rst), .en(en), .stim_in(stim), .dut_out(dout[2]), .busy(busy_o[2]),
    .pass_cnt(pass_o[2]), .err_cnt(err_o[2]), .err_flag(flag_o[2]), .halted(halt_o[2]),
    .first_exp(fexp_o[2]), .first_got(fgot_o[2]));
  reg_resp_checker #(.DWIDTH(32), .LATENCY(2), .CNT_W(4), .STOP_ON_ERR(0)) u3 (
    .clk(clk), .rst(rst), .en(en), .stim_in(stim), .dut_out(dout[3]), .busy(busy_o[3]),
    .pass_cnt(pass3), .err_cnt(err3), .err_flag(flag_o[3]), .halted(halt_o[3]),
    .first_exp(fexp_o[3]), .first_got(fgot_o[3]));

  // One clock of stimulus; f is the corruption the fake DUT applies to this item's response.
  task automatic step(input logic r, input logic e, input logic [31:0] s, input logic [31:0] f);
    snap4_t      snap;
    logic [31:0] x;
    int          mx;
    @(negedge clk);
    rst  = r;
    en   = e;
    stim = s;
    for (int i = 0; i < 4; i++) begin
      dout[i] = (k >= LAT[i]) ? (hist[(k - LAT[i]) % 16] ^ fhist[(k - LAT[i]) % 16]) : 32'd0;
    end
    for (int i = 0; i < 4; i++) begin
      mx = (1 << CW[i]) - 1;
      if (!r) begin
        m[i] = '0;
      end else if (m[i].halted) begin
        m[i].busy = 1'b0;
      end else begin
        // an item is compared LATENCY edges after it was sampled if en stayed high throughout
        if (run >= LAT[i]) begin
          x = hist[(k - LAT[i]) % 16];
          if (x == dout[i]) begin
            if (int'(m[i].pass) < mx) m[i].pass = m[i].pass + 16'd1;
          end else begin
            if (int'(m[i].err) < mx) m[i].err = m[i].err + 16'd1;
            if (!m[i].err_flag) begin
              m[i].err_flag = 1'b1;
              m[i].fexp     = x;
              m[i].fgot     = dout[i];
            end
            if (SOE[i] != 0) m[i].halted = 1'b1;
          end
        end
        m[i].busy = e && !m[i].halted;
      end
      snap[i] = m[i];
    end
    exp_q.push_back(snap);
    run = (!r) ? 0 : (e ? run + 1 : 0);
    hist[k % 16]  = s;
    fhist[k % 16] = f;
    k++;
  endtask

  // Monitor: one expected snapshot per edge, compared just after the edge
  initial begin
    snap4_t e4;
    snap_t  g;
    int     cyc = 0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (exp_q.size() > 0) begin
        e4 = exp_q.pop_front();
        for (int i = 0; i < 4; i++) begin
          g = {busy_o[i], halt_o[i], flag_o[i], pass_o[i], err_o[i], fexp_o[i], fgot_o[i]};
          n_checks++;
          if (g !== e4[i]) begin
            n_fail++;
            $display("FAIL cfg%0d cycle %0d: got busy=%0b halted=%0b err_flag=%0b pass=%0d err=%0d first_exp=%h first_got=%h; expected busy=%0b halted=%0b err_flag=%0b pass=%0d err=%0d first_exp=%h first_got=%h",
                     i, cyc, g.busy, g.halted, g.err_flag, g.pass, g.err, g.fexp, g.fgot,
                     e4[i].busy, e4[i].halted, e4[i].err_flag, e4[i].pass, e4[i].err, e4[i].fexp, e4[i].fgot);
          end
        end
      end
    end
  end

  // Watchdog: the stimulus must finish within a bounded time
  initial begin
    #100000;
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL timeout: stimulus did not complete within the wait bound");
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
    end
  end

  initial begin
    rst  = 1'b0;
    en   = 1'b0;
    stim = 32'd0;
    for (int i = 0; i < 4; i++) dout[i] = 32'd0;
    for (int i = 0; i < 16; i++) begin
      hist[i]  = 32'd0;
      fhist[i] = 32'd0;
    end
    for (int i = 0; i < 4; i++) m[i] = '0;

    repeat (2) step(1'b0, 1'b0, 32'd0, 32'd0);
    @(posedge clk);
    #2;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if ((busy_o[i] !== 1'b0) || (halt_o[i] !== 1'b0) || (flag_o[i] !== 1'b0) ||
          (pass_o[i] !== 16'd0) || (err_o[i] !== 16'd0) ||
          (fexp_o[i] !== 32'd0) || (fgot_o[i] !== 32'd0)) begin
        n_fail++;
        $display("FAIL reset state cfg%0d: busy=%0b halted=%0b err_flag=%0b pass=%0d err=%0d first_exp=%h first_got=%h",
                 i, busy_o[i], halt_o[i], flag_o[i], pass_o[i], err_o[i], fexp_o[i], fgot_o[i]);
      end
    end
    for (int v = 1; v <= 10; v++) step(1'b1, 1'b1, 32'(v), 32'd0);
    repeat (3) step(1'b1, 1'b0, $urandom, 32'd0);
    // two-cycle enable pulse: too short to reach a compare at LATENCY=3
    step(1'b1, 1'b1, 32'h11, 32'd0);
    step(1'b1, 1'b1, 32'h12, 32'd0);
    repeat (4) step(1'b1, 1'b0, 32'd0, 32'd0);
    step(1'b1, 1'b1, 32'hDEADBEEF, 32'h1);
    for (int v = 0; v < 5; v++) step(1'b1, 1'b1, 32'(100 + v), 32'd0);
    repeat (20) step(1'b1, 1'b1, $urandom, 32'd0);
    step(1'b1, 1'b1, $urandom, 32'h80000000);
    repeat (3) step(1'b1, 1'b1, $urandom, 32'd0);
    // reset in the middle of checking, then resume
    step(1'b0, 1'b1, $urandom, 32'd0);
    repeat (3) step(1'b1, 1'b1, $urandom, 32'd0);
    repeat (4) step(1'b1, 1'b0, $urandom, 32'd0);
    for (int n = 0; n < 600; n++) begin
      step(($urandom_range(0, 99) != 0), ($urandom_range(0, 7) != 0), $urandom,
           ($urandom_range(0, 9) == 0) ? (32'd1 << $urandom_range(0, 31)) : 32'd0);
    end
    repeat (4) step(1'b1, 1'b0, 32'd0, 32'd0);
    repeat (2) @(posedge clk);
    #2;
    done = 1'b1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
